// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// BTB entry layout, counter encodings and the IF/ID bundle.
package fetch_pkg;

  localparam int DATA_WIDTH = 32;

  localparam int BTB_WIDTH_DEF = 4;
  localparam int BTB_TAG_W = 14 - BTB_WIDTH_DEF;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] CTR_STRONG_T = 2'b11;

  typedef struct packed {
    logic valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [DATA_WIDTH-1:0] target;
    logic [1:0] ctr;
  } btb_entry_t;

  typedef struct packed {
    logic valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;
  } if_id_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] ctr_step(
    input logic [1:0] ctr,
    input logic taken
  );
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != CTR_STRONG_T)
      res = ctr + 2'd1;
    else if (!taken && ctr != CTR_STRONG_NT)
      res = ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Lookup is combinational; training lands on the clock edge.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int BTB_WIDTH = BTB_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lookup_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  upd,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target
);

  localparam int ENTRIES = 1 << BTB_WIDTH;

  btb_entry_t entries_q [ENTRIES];

  function automatic logic [BTB_WIDTH-1:0] idx_of(
    input logic [DATA_WIDTH-1:0] pc
  );
    return pc[BTB_WIDTH+1:2];
  endfunction

  function automatic logic [BTB_TAG_W-1:0] tag_of(
    input logic [DATA_WIDTH-1:0] pc
  );
    return BTB_TAG_W'(pc[15:0] >> (BTB_WIDTH + 2));
  endfunction

  btb_entry_t rd;
  logic rd_hit;

  assign rd = entries_q[idx_of(lookup_pc)];
  assign rd_hit = rd.valid &&
                  (rd.tag == tag_of(lookup_pc));

  assign pred_taken = rd_hit && rd.ctr[1];
  assign pred_target = pred_taken ? rd.target : '0;

  logic [BTB_WIDTH-1:0] widx;
  logic [BTB_TAG_W-1:0] wtag;
  btb_entry_t cur;
  btb_entry_t wr;
  logic cur_hit;
  logic wen;

  assign widx = idx_of(upd_pc);
  assign wtag = tag_of(upd_pc);
  assign cur = entries_q[widx];
  assign cur_hit = cur.valid && (cur.tag == wtag);

  // Build the trained entry: bump a hit, allocate a taken miss.
  always_comb begin
    wr = cur;
    wen = 1'b0;
    if (upd) begin
      if (cur_hit) begin
        wen = 1'b1;
        wr.ctr = ctr_step(cur.ctr, upd_taken);
        if (upd_taken)
          wr.target = upd_target;
      end else if (upd_taken) begin
        wen = 1'b1;
        wr.valid = 1'b1;
        wr.tag = wtag;
        wr.target = upd_target;
        wr.ctr = CTR_WEAK_TAKEN;
      end
    end
  end

  // Entry array; reset clears valid and parks counters weak-not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
        entries_q[i].tag <= '0;
        entries_q[i].target <= '0;
        entries_q[i].ctr <= CTR_WEAK_NT;
      end
    end else if (wen) begin
      entries_q[widx] <= wr;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[31:16], lookup_pc[1:0],
                         upd_pc[31:16], upd_pc[1:0]};

endmodule

// File: rtl/fetch_stage.sv
// PC generation and IF/ID register ahead of the instruction cache.
// Redirects from EX beat every stall; the BTB steers sequential fetch.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BTB_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] fetch_pc,
  output logic                  predict_fail,
  input  logic [DATA_WIDTH-1:0] icache_inst,
  input  logic                  icache_stall,
  input  logic                  id_stall,
  input  logic                  ex_redirect,
  input  logic [DATA_WIDTH-1:0] ex_redirect_pc,
  input  logic                  ex_bp_update,
  input  logic [DATA_WIDTH-1:0] ex_bp_pc,
  input  logic                  ex_bp_taken,
  input  logic [DATA_WIDTH-1:0] ex_bp_target,
  output logic                  if_id_valid,
  output logic [DATA_WIDTH-1:0] if_id_pc,
  output logic [DATA_WIDTH-1:0] if_id_inst,
  output logic                  if_id_pred_taken,
  output logic [DATA_WIDTH-1:0] if_id_pred_target
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic bp_taken;
  logic [DATA_WIDTH-1:0] bp_target;
  logic stall;
  if_id_t if_id_q;

  fetch_btb #(
    .BTB_WIDTH(BTB_WIDTH)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc_q),
    .pred_taken (bp_taken),
    .pred_target(bp_target),
    .upd        (ex_bp_update),
    .upd_pc     (ex_bp_pc),
    .upd_taken  (ex_bp_taken),
    .upd_target (ex_bp_target)
  );

  assign stall = icache_stall || id_stall;
  assign fetch_pc = pc_q;
  assign predict_fail = ex_redirect;

  // Next-PC select: redirect, hold, predicted target, sequential.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (ex_redirect)
      pc_d = ex_redirect_pc;
    else if (stall)
      pc_d = pc_q;
    else if (bp_taken)
      pc_d = bp_target;
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  // IF/ID: flush, hold on decode stall, bubble on miss, else capture.
  always_ff @(posedge clk) begin
    if (rst || ex_redirect) begin
      if_id_q <= '0;
    end else if (id_stall) begin
      if_id_q <= if_id_q;
    end else if (icache_stall) begin
      if_id_q <= '0;
    end else begin
      if_id_q.valid <= 1'b1;
      if_id_q.pc <= pc_q;
      if_id_q.inst <= icache_inst;
      if_id_q.pred_taken <= bp_taken;
      if_id_q.pred_target <= bp_target;
    end
  end

  assign if_id_valid = if_id_q.valid;
  assign if_id_pc = if_id_q.pc;
  assign if_id_inst = if_id_q.inst;
  assign if_id_pred_taken = if_id_q.pred_taken;
  assign if_id_pred_target = if_id_q.pred_target;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner sequences,
// then random traffic against a rule-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int NENT = 16;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] fetch_pc;
  logic predict_fail;
  logic [31:0] icache_inst;
  logic icache_stall;
  logic id_stall;
  logic ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic ex_bp_update;
  logic [31:0] ex_bp_pc;
  logic ex_bp_taken;
  logic [31:0] ex_bp_target;
  logic if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic if_id_pred_taken;
  logic [31:0] if_id_pred_target;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .BTB_WIDTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .predict_fail     (predict_fail),
    .icache_inst      (icache_inst),
    .icache_stall     (icache_stall),
    .id_stall         (id_stall),
    .ex_redirect      (ex_redirect),
    .ex_redirect_pc   (ex_redirect_pc),
    .ex_bp_update     (ex_bp_update),
    .ex_bp_pc         (ex_bp_pc),
    .ex_bp_taken      (ex_bp_taken),
    .ex_bp_target     (ex_bp_target),
    .if_id_valid      (if_id_valid),
    .if_id_pc         (if_id_pc),
    .if_id_inst       (if_id_inst),
    .if_id_pred_taken (if_id_pred_taken),
    .if_id_pred_target(if_id_pred_target)
  );

  typedef struct {
    logic r, ics, ids, red;
    logic [31:0] rpc;
    logic upd;
    logic [31:0] upc;
    logic utk;
    logic [31:0] utg, inst;
    logic [31:0] e_fpc;
    logic e_v;
    logic [31:0] e_pc, e_inst;
    logic e_pt;
    logic [31:0] e_ptg;
  } vec_t;

  int passed = 0;
  int total = 0;

  function automatic vec_t mk(
    input logic r, ics, ids, red,
    input logic [31:0] rpc,
    input logic upd,
    input logic [31:0] upc,
    input logic utk,
    input logic [31:0] utg, inst, fpc,
    input logic ev,
    input logic [31:0] epc, einst,
    input logic ept,
    input logic [31:0] eptg
  );
    vec_t v;
    v.r = r; v.ics = ics; v.ids = ids; v.red = red;
    v.rpc = rpc; v.upd = upd; v.upc = upc;
    v.utk = utk; v.utg = utg; v.inst = inst;
    v.e_fpc = fpc; v.e_v = ev; v.e_pc = epc;
    v.e_inst = einst; v.e_pt = ept; v.e_ptg = eptg;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, check the edge result.
  task automatic run_vec(input vec_t v, input string tag);
    rst = v.r; icache_stall = v.ics; id_stall = v.ids;
    ex_redirect = v.red; ex_redirect_pc = v.rpc;
    ex_bp_update = v.upd; ex_bp_pc = v.upc;
    ex_bp_taken = v.utk; ex_bp_target = v.utg;
    icache_inst = v.inst;
    #1;
    chk({tag, ".predict_fail"}, 32'(predict_fail), 32'(v.red));
    @(posedge clk);
    #1;
    chk({tag, ".fetch_pc"}, fetch_pc, v.e_fpc);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(v.e_v));
    chk({tag, ".pc"}, if_id_pc, v.e_pc);
    chk({tag, ".inst"}, if_id_inst, v.e_inst);
    chk({tag, ".pred_taken"}, 32'(if_id_pred_taken), 32'(v.e_pt));
    chk({tag, ".pred_target"}, if_id_pred_target, v.e_ptg);
  endtask

  // Reference model state: architectural view, not RTL structure.
  logic [31:0] m_pc;
  logic m_v, m_pt;
  logic [31:0] m_ipc, m_inst, m_ptg;
  bit b_v [NENT];
  int b_tag [NENT];
  logic [31:0] b_tgt [NENT];
  int b_ctr [NENT];

  task automatic model(inout vec_t v);
    int ix, tg;
    bit pt;
    logic [31:0] ptg;
    if (v.r) begin
      m_pc = RESET_PC;
      m_v = 0; m_ipc = 0; m_inst = 0; m_pt = 0; m_ptg = 0;
      for (int i = 0; i < NENT; i++) begin
        b_v[i] = 0; b_tag[i] = 0; b_tgt[i] = 0; b_ctr[i] = 1;
      end
    end else begin
      ix = int'((m_pc >> 2) % NENT);
      tg = int'((m_pc >> 6) % 1024);
      pt = b_v[ix] && b_tag[ix] == tg && b_ctr[ix] >= 2;
      ptg = pt ? b_tgt[ix] : 32'h0;
      if (v.red || (!v.ids && v.ics)) begin
        m_v = 0; m_ipc = 0; m_inst = 0; m_pt = 0; m_ptg = 0;
      end else if (!v.ids) begin
        m_v = 1; m_ipc = m_pc; m_inst = v.inst;
        m_pt = pt; m_ptg = ptg;
      end
      if (v.red)
        m_pc = v.rpc;
      else if (!(v.ics || v.ids))
        m_pc = pt ? ptg : m_pc + 32'd4;
      if (v.upd) begin
        ix = int'((v.upc >> 2) % NENT);
        tg = int'((v.upc >> 6) % 1024);
        if (b_v[ix] && b_tag[ix] == tg) begin
          if (v.utk) begin
            b_ctr[ix] = (b_ctr[ix] == 3) ? 3 : b_ctr[ix] + 1;
            b_tgt[ix] = v.utg;
          end else begin
            b_ctr[ix] = (b_ctr[ix] == 0) ? 0 : b_ctr[ix] - 1;
          end
        end else if (v.utk) begin
          b_v[ix] = 1; b_tag[ix] = tg;
          b_tgt[ix] = v.utg; b_ctr[ix] = 2;
        end
      end
    end
    v.e_fpc = m_pc; v.e_v = m_v; v.e_pc = m_ipc;
    v.e_inst = m_inst; v.e_pt = m_pt; v.e_ptg = m_ptg;
  endtask

  function automatic logic [31:0] rnd_pc();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  vec_t tv[$];
  vec_t v;

  initial begin
    // r ics ids red rpc | upd upc tk tgt | inst | fpc v pc inst pt ptg
    tv.push_back(mk(1,0,0,0,0, 0,0,0,0, 32'h11,
                    0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hA0,
                    32'h4,1,32'h0,32'hA0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hA1,
                    32'h8,1,32'h4,32'hA1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hA2,
                    32'hC,1,32'h8,32'hA2,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hA3,
                    32'h10,1,32'hC,32'hA3,0,0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0,1,0,0,0, 0,0,0,0, 32'hBAD,
                      32'h10,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hDEAD0010,
                    32'h14,1,32'h10,32'hDEAD0010,0,0));
    tv.push_back(mk(0,0,0,0,0, 1,32'h20,1,32'h80, 32'hA5,
                    32'h18,1,32'h14,32'hA5,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hA6,
                    32'h1C,1,32'h18,32'hA6,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hA7,
                    32'h20,1,32'h1C,32'hA7,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hA8,
                    32'h80,1,32'h20,32'hA8,1,32'h80));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hA9,
                    32'h84,1,32'h80,32'hA9,0,0));
    tv.push_back(mk(0,1,1,1,32'h200, 0,0,0,0, 32'hAB,
                    32'h200,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0, 32'hAA,
                    32'h204,1,32'h200,32'hAA,0,0));

    foreach (tv[i])
      run_vec(tv[i], $sformatf("tbl%0d", i));

    // Counter saturation: 4 taken (2 -> 3 capped), 1 not-taken -> 2.
    run_vec(mk(0,0,1,1,32'h400, 1,32'h20,1,32'h80, 0,
               32'h400,0,0,0,0,0), "sat_redir");
    for (int i = 0; i < 3; i++)
      run_vec(mk(0,0,1,0,0, 1,32'h20,1,32'h80, 0,
                 32'h400,0,0,0,0,0), "sat_tk");
    run_vec(mk(0,0,1,0,0, 1,32'h20,0,0, 0,
               32'h400,0,0,0,0,0), "sat_nt1");
    run_vec(mk(0,0,0,1,32'h20, 0,0,0,0, 0,
               32'h20,0,0,0,0,0), "sat_go1");
    run_vec(mk(0,0,0,0,0, 0,0,0,0, 32'hB0,
               32'h80,1,32'h20,32'hB0,1,32'h80), "sat_pred2");
    run_vec(mk(0,0,0,1,32'h400, 1,32'h20,0,0, 0,
               32'h400,0,0,0,0,0), "sat_nt2");
    run_vec(mk(0,0,0,1,32'h20, 0,0,0,0, 0,
               32'h20,0,0,0,0,0), "sat_go2");
    run_vec(mk(0,0,0,0,0, 0,0,0,0, 32'hB1,
               32'h24,1,32'h20,32'hB1,0,0), "sat_pred1");

    // Reset during a live BTB hit with decode stalled.
    run_vec(mk(0,0,0,0,0, 1,32'h20,1,32'h80, 32'hB2,
               32'h28,1,32'h24,32'hB2,0,0), "rh_train");
    run_vec(mk(0,0,0,1,32'h20, 0,0,0,0, 0,
               32'h20,0,0,0,0,0), "rh_go");
    run_vec(mk(1,0,1,0,0, 0,0,0,0, 32'hB9,
               RESET_PC,0,0,0,0,0), "rh_rst");
    run_vec(mk(0,0,0,1,32'h20, 0,0,0,0, 0,
               32'h20,0,0,0,0,0), "rh_go2");
    run_vec(mk(0,0,0,0,0, 0,0,0,0, 32'hB3,
               32'h24,1,32'h20,32'hB3,0,0), "rh_miss");

    // Sequential PC wraps past the top of the address space.
    run_vec(mk(0,0,0,1,32'hFFFF_FFFC, 0,0,0,0, 0,
               32'hFFFF_FFFC,0,0,0,0,0), "wrap_go");
    run_vec(mk(0,0,0,0,0, 0,0,0,0, 32'hB4,
               32'h0,1,32'hFFFF_FFFC,32'hB4,0,0), "wrap");

    // Random traffic against the reference model.
    v = mk(1,0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0,0);
    model(v);
    run_vec(v, "rnd_rst");
    for (int n = 0; n < 600; n++) begin
      v.r = ($urandom_range(0, 99) < 2);
      v.ics = ($urandom_range(0, 99) < 20);
      v.ids = ($urandom_range(0, 99) < 15);
      v.red = ($urandom_range(0, 99) < 10);
      v.rpc = rnd_pc();
      v.upd = ($urandom_range(0, 99) < 35);
      v.upc = rnd_pc();
      v.utk = ($urandom_range(0, 99) < 65);
      v.utg = rnd_pc();
      v.inst = $urandom;
      model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC-generation and IF/ID boundary stage directly upstream of the instruction cache.
- Holds the architectural fetch PC and drives it as the cache lookup address. Raises the mispredict-abandon signal toward the cache, predicts branches with a direct-mapped BTB and 2-bit counters, and registers {pc, inst, prediction} into the IF/ID register for decode.
- Redirects come from EX; stalls come from the cache and the decode hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- BTB_WIDTH, 4, log2 of BTB entries (16 entries by default).

Ports:
- clk  input  1  pipeline clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fetch_pc  output  32  current fetch address to the cache.
- predict_fail  output  1  combinational copy of ex_redirect; tells the cache to abandon the current fill.
- icache_inst  input  32  instruction returned by the cache for fetch_pc.
- icache_stall  input  1  cache miss in progress; fetch_pc must hold.
- id_stall  input  1  decode hazard; hold PC and IF/ID.
- ex_redirect  input  1  EX detected a misprediction.
- ex_redirect_pc  input  32  correct next PC.
- ex_bp_update  input  1  a resolved branch/jump is in EX; train the BTB.
- ex_bp_pc  input  32  PC of the resolved branch.
- ex_bp_taken  input  1  actual direction.
- ex_bp_target  input  32  actual target.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_pc  output  32  PC of the IF/ID instruction.
- if_id_inst  output  32  instruction word.
- if_id_pred_taken  output  1  prediction made at fetch.
- if_id_pred_target  output  32  predicted target (0 when not taken).

Behaviour:
- Reset, synchronous:
  - fetch_pc = RESET_PC.
  - All IF/ID outputs = 0, including if_id_valid = 0.
  - All BTB valid bits = 0 and all counters = 2'b01.
  - Reset overrides every other input.
- Next-PC priority, highest first:
  1. rst.
  2. ex_redirect → ex_redirect_pc.
  3. icache_stall or id_stall → hold.
  4. BTB hit and counter[1] set → stored target.
  5. Otherwise fetch_pc + 4, wrapping mod 2^32.
- predict_fail is purely combinational and equals ex_redirect. It has no register delay.
- BTB lookup, combinational on fetch_pc:
  - index = fetch_pc[BTB_WIDTH+1:2].
  - tag = fetch_pc[15:BTB_WIDTH+2].
  - entry = {valid, tag, target[31:0], ctr[1:0]}.
  - Hit = valid and tag equal.
- BTB update on posedge when ex_bp_update = 1:
  - Hit at ex_bp_pc: counter saturates at 3/0, +1 if taken, −1 if not. On taken, target is rewritten.
  - Miss and taken: allocate {1, tag, ex_bp_target, 2'b10}.
  - Miss and not taken: no change.
- Same-cycle lookup and update to one index: the lookup sees pre-update contents. There is no bypass.
- IF/ID register, posedge, priority highest first:
  1. rst or ex_redirect → flush: valid = 0, all fields 0.
  2. id_stall → hold every field.
  3. icache_stall → bubble: valid = 0, other fields don't-care but driven 0.
  4. Otherwise capture fetch_pc, icache_inst, prediction; valid = 1.
- Latency:
  - Instruction at fetch_pc appears in IF/ID one cycle after the cycle where icache_stall = 0 and no stall/redirect.
  - Redirect: the target is fetched the following cycle, so there is a 1-bubble penalty minimum.
- Simultaneous events:
  - ex_redirect with id_stall or icache_stall: redirect wins and fetch_pc loads the target.
  - ex_redirect with ex_bp_update: both take effect.
  - Reset mid-miss: fetch_pc = RESET_PC next cycle and the cache's own reset clears its state machine.

Decomposition:
- Package fetch_pkg holds:
  - btb_entry_t packed struct {valid, tag, target, ctr}.
  - localparams BTB_TAG_W = 14 − BTB_WIDTH and CTR_WEAK_TAKEN = 2'b10.
  - Constants.vh DATA_WIDTH is used for 32-bit buses.
- Sub-module fetch_btb holds:
  - The entry array.
  - The combinational lookup port.
  - The registered update port.
  - The counter saturation logic.
- fetch_stage holds the PC register, the next-PC mux and the IF/ID register.

Test Plan:
1. Reset then run with icache_stall = 0 and no branches → fetch_pc 0x0, 0x4, 0x8 on successive cycles; if_id_pc lags one cycle; if_id_valid rises on cycle 1.
2. icache_stall held 3 cycles at fetch_pc = 0x10 → fetch_pc stays 0x10 and if_id_valid = 0 for 3 cycles. On release, if_id_inst = icache_inst and pc = 0x10.
3. ex_bp_update taken for pc 0x20 → target 0x80, then fetch 0x20 → BTB allocated with ctr 2'b10. The next fetch of 0x20 predicts taken, fetch_pc becomes 0x80, and if_id_pred_target = 0x80.
4. ex_redirect to 0x200 asserted together with id_stall and icache_stall → predict_fail = 1 that cycle; fetch_pc = 0x200 and if_id_valid = 0 next cycle.
5. Counter saturation: four taken updates, then one not-taken at 0x20 → ctr goes 3 then 2 and still predicts taken. A second not-taken gives ctr = 1, the prediction is not taken, and fetch_pc becomes 0x24.
6. Assert rst while a BTB hit is present and id_stall = 1 → next cycle fetch_pc = RESET_PC, all IF/ID outputs 0, and the former hit address now misses.
